// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU opcodes, control-unit state encoding and strobe bundle
package cpu_pkg;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    typedef enum logic [3:0] {
        S_RESET, S_T0, S_T1, S_T1W, S_T2, S_T3, S_T4,
        S_T5, S_T6, S_T6W, S_T7, S_HALT
    } state_e;

    typedef struct packed {
        logic       run;
        logic       pc_out;
        logic       pc_in;
        logic       pc_inc;
        logic       mar_in;
        logic       mdr_in;
        logic       mdr_out;
        logic       ir_in;
        logic       y_in;
        logic       z_in;
        logic       zlow_out;
        logic       c_out;
        logic       read;
        logic       write;
        logic       gra;
        logic       grb;
        logic       grc;
        logic       r_in;
        logic       r_out;
        logic       ba_out;
        logic [4:0] alu_op;
    } ctrl_t;

    function automatic logic is_rtype(input logic [4:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
    endfunction

    function automatic logic is_itype(input logic [4:0] op);
        return (op == OP_ADDI) || (op == OP_ANDI) || (op == OP_ORI);
    endfunction

    function automatic logic is_mem(input logic [4:0] op);
        return (op == OP_LD) || (op == OP_ST);
    endfunction

    // Immediate forms and address arithmetic reuse the register-form ALU code
    function automatic logic [4:0] base_op(input logic [4:0] op);
        case (op)
            OP_ANDI: return OP_AND;
            OP_ORI:  return OP_OR;
            default: return OP_ADD;
        endcase
    endfunction

endpackage

// File: rtl/control_decode.sv
// rtl/control_decode.sv - Moore output decode: state plus latched opcode to strobe bundle
module control_decode
    import cpu_pkg::*;
(
    input  state_e     state,
    input  logic [4:0] op,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl     = '0;
        ctrl.run = (state != S_RESET) && (state != S_HALT);
        case (state)
            S_T0: begin
                ctrl.pc_out = 1'b1;
                ctrl.mar_in = 1'b1;
                ctrl.pc_inc = 1'b1;
                ctrl.z_in   = 1'b1;
                ctrl.alu_op = OP_ADD;
            end
            S_T1: begin
                ctrl.zlow_out = 1'b1;
                ctrl.pc_in    = 1'b1;
                ctrl.read     = 1'b1;
            end
            S_T1W: begin
                ctrl.read   = 1'b1;
                ctrl.mdr_in = 1'b1;
            end
            S_T2: begin
                ctrl.mdr_out = 1'b1;
                ctrl.ir_in   = 1'b1;
            end
            S_T3: begin
                // NOP, HALT and undefined opcodes pass through T3 silently
                if (is_rtype(op) || is_itype(op)) begin
                    ctrl.grb   = 1'b1;
                    ctrl.r_out = 1'b1;
                    ctrl.y_in  = 1'b1;
                end else if (is_mem(op)) begin
                    ctrl.grb    = 1'b1;
                    ctrl.ba_out = 1'b1;
                    ctrl.y_in   = 1'b1;
                end
            end
            S_T4: begin
                ctrl.z_in = 1'b1;
                if (is_rtype(op)) begin
                    ctrl.grc    = 1'b1;
                    ctrl.r_out  = 1'b1;
                    ctrl.alu_op = op;
                end else begin
                    ctrl.c_out  = 1'b1;
                    ctrl.alu_op = base_op(op);
                end
            end
            S_T5: begin
                ctrl.zlow_out = 1'b1;
                if (is_mem(op)) begin
                    ctrl.mar_in = 1'b1;
                end else begin
                    ctrl.gra  = 1'b1;
                    ctrl.r_in = 1'b1;
                end
            end
            S_T6: begin
                ctrl.mdr_in = 1'b1;
                if (op == OP_ST) begin
                    ctrl.gra   = 1'b1;
                    ctrl.r_out = 1'b1;
                end else begin
                    ctrl.read = 1'b1;
                end
            end
            S_T6W: begin
                if (op == OP_ST) begin
                    ctrl.write = 1'b1;
                end else begin
                    ctrl.read   = 1'b1;
                    ctrl.mdr_in = 1'b1;
                end
            end
            S_T7: begin
                ctrl.mdr_out = 1'b1;
                ctrl.gra     = 1'b1;
                ctrl.r_in    = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// rtl/control_unit.sv - multi-cycle CPU control FSM: fetch, decode and execute sequencing
module control_unit
    import cpu_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       stop,
    input  logic [4:0] ir_op,
    input  logic       mem_done,
    output logic       run,
    output logic       pc_out,
    output logic       pc_in,
    output logic       pc_inc,
    output logic       mar_in,
    output logic       mdr_in,
    output logic       mdr_out,
    output logic       ir_in,
    output logic       y_in,
    output logic       z_in,
    output logic       zlow_out,
    output logic       c_out,
    output logic       read,
    output logic       write,
    output logic       gra,
    output logic       grb,
    output logic       grc,
    output logic       r_in,
    output logic       r_out,
    output logic       ba_out,
    output logic [4:0] alu_op
);

    state_e     state;
    state_e     state_next;
    logic [4:0] op_q;
    ctrl_t      ctrl;

    // op_q captures the opcode as the IR is loaded, so decode sees a stable value
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_RESET;
            op_q  <= '0;
        end else begin
            state <= state_next;
            if (state == S_T2) begin
                op_q <= ir_op;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_RESET: state_next = S_T0;
            S_T0:    state_next = stop ? S_HALT : S_T1;
            S_T1:    state_next = S_T1W;
            S_T1W:   state_next = mem_done ? S_T2 : S_T1W;
            S_T2:    state_next = S_T3;
            S_T3: begin
                if (is_rtype(op_q) || is_itype(op_q) || is_mem(op_q)) begin
                    state_next = S_T4;
                end else if (op_q == OP_NOP) begin
                    state_next = S_T0;
                end else begin
                    state_next = S_HALT;
                end
            end
            S_T4:    state_next = S_T5;
            S_T5:    state_next = is_mem(op_q) ? S_T6 : S_T0;
            S_T6:    state_next = S_T6W;
            S_T6W: begin
                if (mem_done) begin
                    state_next = (op_q == OP_ST) ? S_T0 : S_T7;
                end
            end
            S_T7:    state_next = S_T0;
            S_HALT:  state_next = S_HALT;
            default: state_next = S_RESET;
        endcase
    end

    control_decode u_decode (
        .state (state),
        .op    (op_q),
        .ctrl  (ctrl)
    );

    assign run      = ctrl.run;
    assign pc_out   = ctrl.pc_out;
    assign pc_in    = ctrl.pc_in;
    assign pc_inc   = ctrl.pc_inc;
    assign mar_in   = ctrl.mar_in;
    assign mdr_in   = ctrl.mdr_in;
    assign mdr_out  = ctrl.mdr_out;
    assign ir_in    = ctrl.ir_in;
    assign y_in     = ctrl.y_in;
    assign z_in     = ctrl.z_in;
    assign zlow_out = ctrl.zlow_out;
    assign c_out    = ctrl.c_out;
    assign read     = ctrl.read;
    assign write    = ctrl.write;
    assign gra      = ctrl.gra;
    assign grb      = ctrl.grb;
    assign grc      = ctrl.grc;
    assign r_in     = ctrl.r_in;
    assign r_out    = ctrl.r_out;
    assign ba_out   = ctrl.ba_out;
    assign alu_op   = ctrl.alu_op;

endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - directed cycle-by-cycle checks of the control_unit strobe sequence
module tb_control_unit;

    logic       clk;
    logic       reset;
    logic       stop;
    logic [4:0] ir_op;
    logic       mem_done;
    logic       run, pc_out, pc_in, pc_inc, mar_in, mdr_in, mdr_out, ir_in;
    logic       y_in, z_in, zlow_out, c_out, read, write;
    logic       gra, grb, grc, r_in, r_out, ba_out;
    logic [4:0] alu_op;

    int checks = 0;
    int errors = 0;

    control_unit dut (
        .clk      (clk),
        .reset    (reset),
        .stop     (stop),
        .ir_op    (ir_op),
        .mem_done (mem_done),
        .run      (run),
        .pc_out   (pc_out),
        .pc_in    (pc_in),
        .pc_inc   (pc_inc),
        .mar_in   (mar_in),
        .mdr_in   (mdr_in),
        .mdr_out  (mdr_out),
        .ir_in    (ir_in),
        .y_in     (y_in),
        .z_in     (z_in),
        .zlow_out (zlow_out),
        .c_out    (c_out),
        .read     (read),
        .write    (write),
        .gra      (gra),
        .grb      (grb),
        .grc      (grc),
        .r_in     (r_in),
        .r_out    (r_out),
        .ba_out   (ba_out),
        .alu_op   (alu_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [24:0] obs;
    assign obs = {run, pc_out, pc_in, pc_inc, mar_in, mdr_in, mdr_out, ir_in,
                  y_in, z_in, zlow_out, c_out, read, write,
                  gra, grb, grc, r_in, r_out, ba_out, alu_op};

    localparam logic [24:0] B_RUN   = 25'd1 << 24;
    localparam logic [24:0] B_PCO   = 25'd1 << 23;
    localparam logic [24:0] B_PCI   = 25'd1 << 22;
    localparam logic [24:0] B_PCINC = 25'd1 << 21;
    localparam logic [24:0] B_MARI  = 25'd1 << 20;
    localparam logic [24:0] B_MDRI  = 25'd1 << 19;
    localparam logic [24:0] B_MDRO  = 25'd1 << 18;
    localparam logic [24:0] B_IRI   = 25'd1 << 17;
    localparam logic [24:0] B_YI    = 25'd1 << 16;
    localparam logic [24:0] B_ZI    = 25'd1 << 15;
    localparam logic [24:0] B_ZLO   = 25'd1 << 14;
    localparam logic [24:0] B_CO    = 25'd1 << 13;
    localparam logic [24:0] B_RD    = 25'd1 << 12;
    localparam logic [24:0] B_WR    = 25'd1 << 11;
    localparam logic [24:0] B_GRA   = 25'd1 << 10;
    localparam logic [24:0] B_GRB   = 25'd1 << 9;
    localparam logic [24:0] B_GRC   = 25'd1 << 8;
    localparam logic [24:0] B_RI    = 25'd1 << 7;
    localparam logic [24:0] B_RO    = 25'd1 << 6;
    localparam logic [24:0] B_BAO   = 25'd1 << 5;

    localparam logic [24:0] E_OFF    = 25'd0;
    localparam logic [24:0] E_T0     = B_RUN | B_PCO | B_MARI | B_PCINC | B_ZI | 25'd3;
    localparam logic [24:0] E_T1     = B_RUN | B_ZLO | B_PCI | B_RD;
    localparam logic [24:0] E_T1W    = B_RUN | B_RD | B_MDRI;
    localparam logic [24:0] E_T2     = B_RUN | B_MDRO | B_IRI;
    localparam logic [24:0] E_T3R    = B_RUN | B_GRB | B_RO | B_YI;
    localparam logic [24:0] E_T4ADD  = B_RUN | B_GRC | B_RO | B_ZI | 25'd3;
    localparam logic [24:0] E_T4SUB  = B_RUN | B_GRC | B_RO | B_ZI | 25'd4;
    localparam logic [24:0] E_T5R    = B_RUN | B_ZLO | B_GRA | B_RI;
    localparam logic [24:0] E_T4ADDI = B_RUN | B_CO | B_ZI | 25'd3;
    localparam logic [24:0] E_T4ORI  = B_RUN | B_CO | B_ZI | 25'd6;
    localparam logic [24:0] E_T3M    = B_RUN | B_GRB | B_BAO | B_YI;
    localparam logic [24:0] E_T4M    = B_RUN | B_CO | B_ZI | 25'd3;
    localparam logic [24:0] E_T5M    = B_RUN | B_ZLO | B_MARI;
    localparam logic [24:0] E_T6LD   = B_RUN | B_RD | B_MDRI;
    localparam logic [24:0] E_T7     = B_RUN | B_MDRO | B_GRA | B_RI;
    localparam logic [24:0] E_T6ST   = B_RUN | B_GRA | B_RO | B_MDRI;
    localparam logic [24:0] E_T6WST  = B_RUN | B_WR;
    localparam logic [24:0] E_IDLE   = B_RUN;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        stop = 1'b0;
        mem_done = 1'b1;
        ir_op = 5'b00011;
        tick();
        tick();
        checks++;
        if (obs !== E_OFF) begin
            errors++;
            $display("FAIL reset_state got %h want %h", obs, E_OFF);
        end
        reset = 1'b0;
        tick();
        checks++;
        if (obs !== E_T0) begin
            errors++;
            $display("FAIL reset_to_t0 got %h want %h", obs, E_T0);
        end
    endtask

    task automatic test_rtype();
        logic [24:0] seq[$];
        do_reset();
        ir_op = 5'b00011;
        mem_done = 1'b1;
        seq = '{E_T0, E_T1, E_T1W, E_T2, E_T3R, E_T4ADD, E_T5R, E_T0,
                E_T1, E_T1W, E_T2, E_T3R, E_T4SUB, E_T5R, E_T0};
        for (int i = 0; i < seq.size(); i++) begin
            // second instruction is SUB, presented during its T0
            if (i == 7) ir_op = 5'b00100;
            checks++;
            if (obs !== seq[i]) begin
                errors++;
                $display("FAIL rtype step %0d got %h want %h", i, obs, seq[i]);
            end
            if (i < seq.size() - 1) tick();
        end
    endtask

    task automatic test_itype();
        logic [24:0] seq[$];
        do_reset();
        ir_op = 5'b01100;
        mem_done = 1'b1;
        seq = '{E_T0, E_T1, E_T1W, E_T2, E_T3R, E_T4ADDI, E_T5R, E_T0,
                E_T1, E_T1W, E_T2, E_T3R, E_T4ORI, E_T5R, E_T0};
        for (int i = 0; i < seq.size(); i++) begin
            if (i == 7) ir_op = 5'b01110;
            checks++;
            if (obs !== seq[i]) begin
                errors++;
                $display("FAIL itype step %0d got %h want %h", i, obs, seq[i]);
            end
            if (i < seq.size() - 1) tick();
        end
    endtask

    task automatic test_load();
        logic [24:0] seq[$];
        do_reset();
        ir_op = 5'b00000;
        seq = '{E_T0, E_T1, E_T1W, E_T2, E_T3M, E_T4M, E_T5M, E_T6LD,
                E_T6LD, E_T6LD, E_T6LD, E_T6LD, E_T7, E_T0};
        for (int i = 0; i < seq.size(); i++) begin
            mem_done = (i >= 8 && i <= 10) ? 1'b0 : 1'b1;
            checks++;
            if (obs !== seq[i]) begin
                errors++;
                $display("FAIL load step %0d got %h want %h", i, obs, seq[i]);
            end
            if (i < seq.size() - 1) tick();
        end
    endtask

    task automatic test_store();
        logic [24:0] seq[$];
        do_reset();
        ir_op = 5'b00010;
        seq = '{E_T0, E_T1, E_T1W, E_T2, E_T3M, E_T4M, E_T5M, E_T6ST,
                E_T6WST, E_T6WST, E_T6WST, E_T0};
        for (int i = 0; i < seq.size(); i++) begin
            mem_done = (i == 8 || i == 9) ? 1'b0 : 1'b1;
            checks++;
            if (obs !== seq[i] || r_in !== 1'b0) begin
                errors++;
                $display("FAIL store step %0d got %h want %h", i, obs, seq[i]);
            end
            if (i < seq.size() - 1) tick();
        end
    endtask

    task automatic test_nop_stop_ignored();
        logic [24:0] seq[$];
        do_reset();
        ir_op = 5'b11010;
        mem_done = 1'b1;
        seq = '{E_T0, E_T1, E_T1W, E_T2, E_IDLE, E_T0, E_T1};
        for (int i = 0; i < seq.size(); i++) begin
            stop = (i >= 1 && i <= 4) ? 1'b1 : 1'b0;
            checks++;
            if (obs !== seq[i]) begin
                errors++;
                $display("FAIL nop step %0d got %h want %h", i, obs, seq[i]);
            end
            if (i < seq.size() - 1) tick();
        end
        stop = 1'b0;
    endtask

    task automatic test_reset_in_wait();
        do_reset();
        ir_op = 5'b00011;
        mem_done = 1'b0;
        tick();
        tick();
        tick();
        checks++;
        if (obs !== E_T1W) begin
            errors++;
            $display("FAIL wait_hold got %h want %h", obs, E_T1W);
        end
        reset = 1'b1;
        mem_done = 1'b1;
        tick();
        checks++;
        if (obs !== E_OFF) begin
            errors++;
            $display("FAIL reset_in_wait got %h want %h", obs, E_OFF);
        end
        reset = 1'b0;
        tick();
        checks++;
        if (obs !== E_T0) begin
            errors++;
            $display("FAIL refetch_t0 got %h want %h", obs, E_T0);
        end
        tick();
        checks++;
        if (obs !== E_T1) begin
            errors++;
            $display("FAIL refetch_t1 got %h want %h", obs, E_T1);
        end
    endtask

    task automatic test_halt_opcode();
        logic [24:0] seq[$];
        do_reset();
        ir_op = 5'b11111;
        mem_done = 1'b1;
        seq = '{E_T0, E_T1, E_T1W, E_T2, E_IDLE};
        for (int i = 0; i < seq.size(); i++) begin
            checks++;
            if (obs !== seq[i]) begin
                errors++;
                $display("FAIL halt_op step %0d got %h want %h", i, obs, seq[i]);
            end
            tick();
        end
        for (int i = 0; i < 10; i++) begin
            mem_done = i[0];
            stop = ~i[0];
            ir_op = 5'b00011;
            checks++;
            if (obs !== E_OFF || run !== 1'b0) begin
                errors++;
                $display("FAIL halt_op_hold cycle %0d got %h want %h", i, obs, E_OFF);
            end
            tick();
        end
        stop = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        checks++;
        if (obs !== E_T0) begin
            errors++;
            $display("FAIL halt_exit got %h want %h", obs, E_T0);
        end
    endtask

    task automatic test_stop();
        do_reset();
        ir_op = 5'b00011;
        mem_done = 1'b1;
        stop = 1'b1;
        tick();
        stop = 1'b0;
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (obs !== E_OFF || run !== 1'b0) begin
                errors++;
                $display("FAIL stop_hold cycle %0d got %h want %h", i, obs, E_OFF);
            end
            tick();
        end
    endtask

    initial begin
        reset = 1'b1;
        stop = 1'b0;
        ir_op = 5'b0;
        mem_done = 1'b0;
        test_reset();
        test_rtype();
        test_itype();
        test_load();
        test_store();
        test_nop_stop_ignored();
        test_reset_in_wait();
        test_halt_opcode();
        test_stop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
